tictactoe_ctrl: RTL and testbench

//  Game sequencer around the combinational tictactoe checker. Owns the 9-cell X/O board

---
 rtl/tictactoe_pkg.sv | 32 +++
 rtl/tictactoe.sv | 26 ++
 rtl/tictactoe_ctrl.sv | 149 ++++++++++++++
 tb/tb_tictactoe_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared types and helpers for the tic-tac-toe game sequencer
package tictactoe_pkg;

   localparam int NUM_CELLS = 9;

   typedef logic [3:0] cell_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TURN  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_X    = 2'b01,
      RES_O    = 2'b10,
      RES_DRAW = 2'b11
   } result_e;

   // One-hot board mask for a cell index; out-of-range indices give an empty mask
   function automatic logic [NUM_CELLS-1:0] cell_mask(input cell_t c);
      logic [NUM_CELLS-1:0] m;
      m = '0;
      if (c < cell_t'(NUM_CELLS)) begin
         m[c] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/tictactoe.sv
// rtl/tictactoe.sv - combinational board checker: win, full and inconsistency detection
module tictactoe (
   input  logic [8:0] x,
   input  logic [8:0] o,
   output logic       error,
   output logic       full,
   output logic       winX,
   output logic       winO,
   output logic       noWin
);

   // Any of the eight lines (three rows, three columns, two diagonals) fully occupied
   function automatic logic has_line(input logic [8:0] b);
      return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
             (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
             (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
   endfunction

   assign winX  = has_line(x);
   assign winO  = has_line(o);
   assign noWin = ~winX & ~winO;
   assign full  = &(x | o);
   // A cell owned by both players, or both players winning, can only come from a corrupted board
   assign error = (|(x & o)) | (winX & winO);

endmodule

// File: rtl/tictactoe_ctrl.sv
// rtl/tictactoe_ctrl.sv - game sequencer: board registers, turn handshake, result and timeout
module tictactoe_ctrl
   import tictactoe_pkg::*;
#(
   parameter bit          X_FIRST      = 1'b1,
   parameter int unsigned TURN_TIMEOUT = 0,
   parameter int unsigned TO_W         = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       move_valid,
   input  logic       move_player,
   input  logic [3:0] move_cell,
   output logic       move_ready,
   output logic       illegal_move,
   output logic [8:0] board_x,
   output logic [8:0] board_o,
   output logic       turn_o,
   output logic [3:0] move_count,
   output logic       busy,
   output logic       done,
   output logic [1:0] result,
   output logic       fault
);

   state_e          state_q;
   logic [8:0]      board_x_q;
   logic [8:0]      board_o_q;
   logic            turn_q;
   logic [3:0]      count_q;
   result_e         result_q;
   logic            fault_q;
   logic            illegal_q;
   logic [TO_W-1:0] timer_q;

   logic            chk_err;
   logic            chk_full;
   logic            chk_winx;
   logic            chk_wino;
   logic            chk_nowin;

   logic [8:0]      move_mask;
   logic            handshake;
   logic            legal;
   logic            timeout_hit;

   // Checker always evaluates the registered boards; only CHECK acts on its verdict
   tictactoe u_checker (
      .x     (board_x_q),
      .o     (board_o_q),
      .error (chk_err),
      .full  (chk_full),
      .winX  (chk_winx),
      .winO  (chk_wino),
      .noWin (chk_nowin)
   );

   assign move_mask   = cell_mask(cell_t'(move_cell));
   assign handshake   = move_valid && (state_q == TURN);
   assign legal       = (move_player == turn_q) &&
                        (move_cell < cell_t'(NUM_CELLS)) &&
                        ((move_mask & (board_x_q | board_o_q)) == '0);
   assign timeout_hit = (TURN_TIMEOUT != 0) && (timer_q == TO_W'(TURN_TIMEOUT - 1));

   // Game FSM: owns boards, turn, move counter, turn timer and all result flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         board_x_q <= '0;
         board_o_q <= '0;
         turn_q    <= 1'b0;
         count_q   <= '0;
         result_q  <= RES_NONE;
         fault_q   <= 1'b0;
         illegal_q <= 1'b0;
         timer_q   <= '0;
      end else begin
         illegal_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  board_x_q <= '0;
                  board_o_q <= '0;
                  count_q   <= '0;
                  result_q  <= RES_NONE;
                  fault_q   <= 1'b0;
                  turn_q    <= ~X_FIRST;
                  timer_q   <= '0;
                  state_q   <= TURN;
               end
            end
            TURN: begin
               if (handshake && legal) begin
                  // A legal move on the timeout edge still counts
                  if (turn_q) begin
                     board_o_q <= board_o_q | move_mask;
                  end else begin
                     board_x_q <= board_x_q | move_mask;
                  end
                  count_q <= count_q + 4'd1;
                  state_q <= CHECK;
               end else begin
                  if (handshake) begin
                     illegal_q <= 1'b1;
                  end
                  if (timeout_hit) begin
                     // The player who ran out of time forfeits to the opponent
                     result_q <= turn_q ? RES_X : RES_O;
                     state_q  <= DONE;
                  end else if (TURN_TIMEOUT != 0) begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
            end
            CHECK: begin
               if (chk_err) begin
                  fault_q  <= 1'b1;
                  result_q <= RES_NONE;
                  state_q  <= DONE;
               end else if (!chk_nowin) begin
                  result_q <= chk_winx ? RES_X : RES_O;
                  state_q  <= DONE;
               end else if (chk_full) begin
                  result_q <= RES_DRAW;
                  state_q  <= DONE;
               end else begin
                  turn_q  <= ~turn_q;
                  timer_q <= '0;
                  state_q <= TURN;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign move_ready   = (state_q == TURN);
   assign busy         = (state_q == TURN) || (state_q == CHECK);
   assign done         = (state_q == DONE);
   assign illegal_move = illegal_q;
   assign board_x      = board_x_q;
   assign board_o      = board_o_q;
   assign turn_o       = turn_q;
   assign move_count   = count_q;
   assign result       = result_q;
   assign fault        = fault_q;

endmodule

// File: tb/tb_tictactoe_ctrl.sv
// tb/tb_tictactoe_ctrl.sv - scoreboard bench for the tic-tac-toe game sequencer
module tb_tictactoe_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start_a, start_b;
   logic       move_valid_a, move_valid_b;
   logic       move_player;
   logic [3:0] move_cell;

   logic       ready_a, ill_a, turn_a, busy_a, done_a, fault_a;
   logic [8:0] bx_a, bo_a;
   logic [3:0] cnt_a;
   logic [1:0] res_a;

   logic       ready_b, ill_b, turn_b, busy_b, done_b, fault_b;
   logic [8:0] bx_b, bo_b;
   logic [3:0] cnt_b;
   logic [1:0] res_b;

   tictactoe_ctrl #(.X_FIRST(1'b1), .TURN_TIMEOUT(0), .TO_W(16)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .move_valid(move_valid_a),
      .move_player(move_player), .move_cell(move_cell), .move_ready(ready_a),
      .illegal_move(ill_a), .board_x(bx_a), .board_o(bo_a), .turn_o(turn_a),
      .move_count(cnt_a), .busy(busy_a), .done(done_a), .result(res_a), .fault(fault_a)
   );

   tictactoe_ctrl #(.X_FIRST(1'b1), .TURN_TIMEOUT(4), .TO_W(16)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .move_valid(move_valid_b),
      .move_player(move_player), .move_cell(move_cell), .move_ready(ready_b),
      .illegal_move(ill_b), .board_x(bx_b), .board_o(bo_b), .turn_o(turn_b),
      .move_count(cnt_b), .busy(busy_b), .done(done_b), .result(res_b), .fault(fault_b)
   );

   typedef struct {
      logic [8:0] bx;
      logic [8:0] bo;
      logic       turn;
      logic [3:0] cnt;
      logic       done;
      logic [1:0] res;
      logic       ill;
   } snap_t;

   snap_t sb_q[$];

   int checks = 0;
   int errors = 0;

   logic [8:0] m_bx, m_bo;
   logic       m_turn, m_done;
   logic [3:0] m_cnt;
   logic [1:0] m_res;

   logic [8:0] lines [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit won(input logic [8:0] b);
      for (int i = 0; i < 8; i++) begin
         if ((b & lines[i]) == lines[i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_bx = '0; m_bo = '0; m_turn = 1'b0; m_done = 1'b0; m_cnt = '0; m_res = 2'b00;
   endtask

   task automatic wait_ready_a();
      int n;
      n = 0;
      while (!ready_a && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) check_eq("ready_wait_expired", 32'(ready_a), 32'd1);
   endtask

   // Model the move, push the expectation, drive the handshake, then pop and compare
   task automatic do_move(input bit p, input int c);
      snap_t      s;
      logic [8:0] bm;
      bit         ill;
      bm = '0;
      if (c < 9) bm[c] = 1'b1;
      ill = (p != m_turn) || (c > 8) || (((m_bx | m_bo) & bm) != '0);
      if (!ill) begin
         if (p) m_bo = m_bo | bm;
         else   m_bx = m_bx | bm;
         m_cnt = m_cnt + 4'd1;
         if (won(m_bx))            begin m_done = 1'b1; m_res = 2'b01; end
         else if (won(m_bo))       begin m_done = 1'b1; m_res = 2'b10; end
         else if (&(m_bx | m_bo))  begin m_done = 1'b1; m_res = 2'b11; end
         else                      m_turn = ~m_turn;
      end
      s.bx = m_bx; s.bo = m_bo; s.turn = m_turn; s.cnt = m_cnt;
      s.done = m_done; s.res = m_res; s.ill = ill;
      sb_q.push_back(s);

      wait_ready_a();
      move_valid_a = 1'b1;
      move_player  = p;
      move_cell    = 4'(c);
      @(posedge clk);
      @(negedge clk);
      move_valid_a = 1'b0;

      s = sb_q.pop_front();
      check_eq("illegal_pulse", 32'(ill_a), 32'(s.ill));
      if (!s.ill) begin
         @(posedge clk);
         @(negedge clk);
      end
      check_eq("board_x",    32'(bx_a),    32'(s.bx));
      check_eq("board_o",    32'(bo_a),    32'(s.bo));
      check_eq("turn",       32'(turn_a),  32'(s.turn));
      check_eq("move_count", 32'(cnt_a),   32'(s.cnt));
      check_eq("done",       32'(done_a),  32'(s.done));
      check_eq("busy",       32'(busy_a),  32'(!s.done));
      check_eq("result",     32'(res_a),   32'(s.res));
      check_eq("fault",      32'(fault_a), 32'd0);
   endtask

   task automatic start_game_a();
      start_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_a = 1'b0;
      model_reset();
      check_eq("start_board_x", 32'(bx_a),    32'd0);
      check_eq("start_board_o", 32'(bo_a),    32'd0);
      check_eq("start_turn",    32'(turn_a),  32'd0);
      check_eq("start_count",   32'(cnt_a),   32'd0);
      check_eq("start_done",    32'(done_a),  32'd0);
      check_eq("start_result",  32'(res_a),   32'd0);
      check_eq("start_busy",    32'(busy_a),  32'd1);
      check_eq("start_ready",   32'(ready_a), 32'd1);
   endtask

   task automatic check_all_zero_a(input string tag);
      check_eq({tag, "_bx"},    32'(bx_a),    32'd0);
      check_eq({tag, "_bo"},    32'(bo_a),    32'd0);
      check_eq({tag, "_turn"},  32'(turn_a),  32'd0);
      check_eq({tag, "_cnt"},   32'(cnt_a),   32'd0);
      check_eq({tag, "_busy"},  32'(busy_a),  32'd0);
      check_eq({tag, "_done"},  32'(done_a),  32'd0);
      check_eq({tag, "_res"},   32'(res_a),   32'd0);
      check_eq({tag, "_ready"}, 32'(ready_a), 32'd0);
      check_eq({tag, "_ill"},   32'(ill_a),   32'd0);
      check_eq({tag, "_fault"}, 32'(fault_a), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
      move_valid_a = 1'b0; move_valid_b = 1'b0; move_player = 1'b0; move_cell = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero_a("reset");
      check_eq("reset_b_busy", 32'(busy_b), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Asynchronous reset in the middle of a game with board_x = 003
      start_game_a();
      do_move(1'b0, 0);
      do_move(1'b1, 4);
      do_move(1'b0, 1);
      rst_n = 1'b0;
      #1;
      check_all_zero_a("midgame_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_game_a();

      // X wins on the top row, with illegal attempts mixed in
      do_move(1'b1, 0);
      do_move(1'b0, 0);
      do_move(1'b1, 0);
      do_move(1'b1, 9);
      @(posedge clk);
      @(negedge clk);
      check_eq("illegal_one_cycle", 32'(ill_a), 32'd0);
      do_move(1'b1, 15);
      do_move(1'b1, 4);
      do_move(1'b0, 1);
      do_move(1'b1, 8);
      do_move(1'b0, 2);
      check_eq("win_board_x", 32'(bx_a), 32'h007);
      check_eq("win_board_o", 32'(bo_a), 32'h110);

      // Start from DONE clears; start held during TURN/CHECK is ignored; game ends in a draw
      start_game_a();
      do_move(1'b0, 0);
      start_a = 1'b1;
      do_move(1'b1, 1);
      do_move(1'b0, 2);
      start_a = 1'b0;
      do_move(1'b1, 4);
      do_move(1'b0, 3);
      do_move(1'b1, 5);
      do_move(1'b0, 7);
      do_move(1'b1, 6);
      do_move(1'b0, 8);
      check_eq("draw_result", 32'(res_a), 32'h3);
      check_eq("draw_board_x", 32'(bx_a), 32'h18D);

      // Ninth move that completes a diagonal reports a win
      start_game_a();
      do_move(1'b0, 0);
      do_move(1'b1, 1);
      do_move(1'b0, 2);
      do_move(1'b1, 5);
      do_move(1'b0, 3);
      do_move(1'b1, 6);
      do_move(1'b0, 4);
      do_move(1'b1, 7);
      do_move(1'b0, 8);
      check_eq("ninth_win_count", 32'(cnt_a), 32'd9);

      // Timeout instance: X idle forfeits after four TURN cycles
      start_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_b = 1'b0;
      check_eq("to_busy", 32'(busy_b), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("to_not_yet", 32'(done_b), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_eq("to_done", 32'(done_b), 32'd1);
      check_eq("to_result_x_idle", 32'(res_b), 32'h2);

      // Legal move on the final timeout cycle wins over the forfeit
      start_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("to_last_ready", 32'(ready_b), 32'd1);
      move_valid_b = 1'b1;
      move_player  = 1'b0;
      move_cell    = 4'd4;
      @(posedge clk);
      @(negedge clk);
      move_valid_b = 1'b0;
      check_eq("to_move_done", 32'(done_b), 32'd0);
      check_eq("to_move_bx", 32'(bx_b), 32'h010);
      @(posedge clk);
      @(negedge clk);
      check_eq("to_move_turn", 32'(turn_b), 32'd1);
      check_eq("to_move_still_busy", 32'(busy_b), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("to_o_not_yet", 32'(done_b), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_eq("to_o_done", 32'(done_b), 32'd1);
      check_eq("to_result_o_idle", 32'(res_b), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
